// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU requester and unified RAM port signals of the memory arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              halt;
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              ihit;
  logic              dhit;
  logic [DATA_W-1:0] iload;
  logic [DATA_W-1:0] dload;
  logic              ram_REN;
  logic              ram_WEN;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;
  logic [DATA_W-1:0] ram_load;
  logic              ram_ready;
  modport slave (
    input  halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
    output ihit, dhit, iload, dload, ram_REN, ram_WEN, ram_addr, ram_store
  );
  modport master (
    output halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
    input  ihit, dhit, iload, dload, ram_REN, ram_WEN, ram_addr, ram_store
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and data memory with a starvation guard
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic CLK,
  input logic nRST,
  mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [2:0] {IDLE, IBUSY, DBUSY, IHIT, DHIT} state_t;
  state_t            state_q;
  logic [SW-1:0]     starve_q, starve_d;
  logic              ren_q, wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] store_q, iload_q, dload_q;
  logic              dreq, dgnt, ignt;
  // data wins unless instruction fetch has lost STARVE_MAX contested rounds in a row
  always_comb begin
    dreq     = bus.dREN | bus.dWEN;
    dgnt     = !bus.halt && dreq && (!bus.iREN || starve_q < SW'(STARVE_MAX));
    ignt     = !bus.halt && !dgnt && bus.iREN;
    starve_d = dgnt ? (bus.iREN ? starve_q + SW'(1) : '0) : ignt ? '0 : starve_q;
  end
  // arbitration FSM: latch grant, wait for RAM, one hit cycle, back to idle
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      iload_q  <= '0;
      dload_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          starve_q <= starve_d;
          if (dgnt) begin
            state_q <= DBUSY;
            addr_q  <= bus.daddr;
            store_q <= bus.dstore;
            wen_q   <= bus.dWEN;
            ren_q   <= bus.dREN & ~bus.dWEN;
          end else if (ignt) begin
            state_q <= IBUSY;
            addr_q  <= bus.iaddr;
            store_q <= bus.dstore;
            wen_q   <= 1'b0;
            ren_q   <= 1'b1;
          end
        end
        IBUSY: if (bus.ram_ready) begin
          iload_q <= bus.ram_load;
          ren_q   <= 1'b0;
          wen_q   <= 1'b0;
          state_q <= IHIT;
        end
        DBUSY: if (bus.ram_ready) begin
          if (ren_q) dload_q <= bus.ram_load;
          ren_q   <= 1'b0;
          wen_q   <= 1'b0;
          state_q <= DHIT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.ihit      = state_q == IHIT;
  assign bus.dhit      = state_q == DHIT;
  assign bus.iload     = iload_q;
  assign bus.dload     = dload_q;
  assign bus.ram_REN   = ren_q;
  assign bus.ram_WEN   = wen_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_store = store_q;
endmodule
